// File: rtl/rgb_sram_writer.sv
// rgb_sram_writer: packs pairs of 24-bit RGB pixels into three 16-bit words
// and writes them to consecutive SRAM addresses of the RGB region.
// A two-slot pair buffer feeds a three-word write engine. The engine can take
// a new pair on the edge that ends its third word, so a continuous pixel
// stream produces back-to-back writes.
module rgb_sram_writer #(
  parameter int BASE_ADDR  = 146944,
  parameter int NUM_PIXELS = 76800,
  parameter int ADDR_W     = 18
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              start,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(NUM_PIXELS + 1);
  localparam logic [CNT_W-1:0]  NUM_C    = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [23:0]        p0_reg, p1_reg;      // pair buffer slots, {R,G,B}
  logic [1:0]         count_reg;           // filled slots, 0..2
  logic [CNT_W-1:0]   pix_cnt_reg;         // pixels accepted this frame
  logic [47:0]        pair_reg;            // pair held by the engine, {p0,p1}
  logic [1:0]         word_idx_reg;        // word currently presented, 0..2
  logic               eng_active_reg;      // engine presenting a word now
  logic [ADDR_W-1:0]  addr_ptr_reg;        // next address to write

  logic accept;
  logic eng_free;
  logic load;
  logic frame_end;

  assign accept   = pixel_valid && pixel_ready;
  // Engine is free when idle or in the last cycle of its current pair.
  assign eng_free = !eng_active_reg || (word_idx_reg == 2'd2);
  assign load     = (state_reg == S_ACTIVE) && (count_reg == 2'd2) && eng_free;
  // Final word of the frame is on the bus and nothing is left to write.
  assign frame_end = (state_reg == S_ACTIVE) && eng_active_reg &&
                     (word_idx_reg == 2'd2) && (count_reg == 2'd0) &&
                     (pix_cnt_reg == NUM_C);

  // State register.
  always_ff @(posedge Clock_50) begin
    if (Reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: start only counts in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_ACTIVE;
      S_ACTIVE: if (frame_end) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FSM outputs, derived from registers only.
  always_comb begin
    pixel_ready = (state_reg == S_ACTIVE) && (count_reg != 2'd2) &&
                  (pix_cnt_reg < NUM_C);
    busy        = (state_reg == S_ACTIVE);
    done        = (state_reg == S_DONE);
  end

  // Pair buffer fill and hand-off to the engine; frame pixel counter.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      p0_reg      <= '0;
      p1_reg      <= '0;
      count_reg   <= 2'd0;
      pix_cnt_reg <= '0;
      pair_reg    <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      count_reg   <= 2'd0;
      pix_cnt_reg <= '0;
    end else begin
      if (load) begin
        pair_reg <= {p0_reg, p1_reg};
        if (accept) begin
          p0_reg    <= {R, G, B};
          count_reg <= 2'd1;
        end else begin
          count_reg <= 2'd0;
        end
      end else if (accept) begin
        if (count_reg == 2'd0) begin
          p0_reg    <= {R, G, B};
          count_reg <= 2'd1;
        end else begin
          p1_reg    <= {R, G, B};
          count_reg <= 2'd2;
        end
      end
      if (accept) pix_cnt_reg <= pix_cnt_reg + CNT_ONE;
    end
  end

  // Write engine: word0 comes straight from the buffer on the load edge,
  // words 1 and 2 from the latched pair on the next two edges.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= BASE_C;
      SRAM_write_data <= 16'h0000;
      word_idx_reg    <= 2'd0;
      eng_active_reg  <= 1'b0;
      addr_ptr_reg    <= BASE_C;
    end else begin
      if ((state_reg == S_IDLE) && start) addr_ptr_reg <= BASE_C;
      if (load) begin
        SRAM_write_data <= p0_reg[23:8];            // {R0,G0}
        SRAM_address    <= addr_ptr_reg;
        addr_ptr_reg    <= addr_ptr_reg + ADDR_ONE;
        SRAM_we_n       <= 1'b0;
        word_idx_reg    <= 2'd0;
        eng_active_reg  <= 1'b1;
      end else if (eng_active_reg && (word_idx_reg != 2'd2)) begin
        SRAM_write_data <= (word_idx_reg == 2'd0) ? pair_reg[31:16]   // {B0,R1}
                                                  : pair_reg[15:0];   // {G1,B1}
        SRAM_address    <= addr_ptr_reg;
        addr_ptr_reg    <= addr_ptr_reg + ADDR_ONE;
        SRAM_we_n       <= 1'b0;
        word_idx_reg    <= word_idx_reg + 2'd1;
      end else begin
        SRAM_we_n       <= 1'b1;
        eng_active_reg  <= 1'b0;
      end
    end
  end

endmodule
